// File: rtl/hsi_s_rx_ctrl_pkg.sv
// Shared constants for the slave-side HSI receiver: flag bytes, CRC16-CCITT parameters, FSM encoding.
package hsi_s_rx_ctrl_pkg;

    localparam logic [7:0] FLAG_STATUS_REQUEST        = 8'hA1;
    localparam logic [7:0] FLAG_CONTROL_COMMAND_WORD  = 8'hA2;
    localparam logic [7:0] FLAG_DATA_PACKET_REQUEST   = 8'hA3;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PAYLOAD = 3'd1;
    localparam logic [2:0] ST_CRC_HI  = 3'd2;
    localparam logic [2:0] ST_CRC_LO  = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_DISCARD = 3'd5;

    // One byte through the CRC, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_citt_calc.sv
// Byte-wide CRC16-CCITT accumulator; n_rst low (sampled on clk) returns it to the init value.
module crc16_citt_calc
    import hsi_s_rx_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (!n_rst)  crc <= CRC16_INIT;
        else if (en) crc <= crc16_byte(crc, d);
    end

endmodule

// File: rtl/hsi_s_rx_ctrl.sv
// Slave HSI frame receiver: FLAG + payload + CRC16 parse and check, payload streaming.
// Optional error counter enabled by defining HSI_RX_ERR_CNT_EN.
module hsi_s_rx_ctrl
    import hsi_s_rx_ctrl_pkg::*;
#(
    parameter int GAP_TIMEOUT = 64,
    parameter int CCW_LEN     = 2,
    parameter int DPR_LEN     = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clk_en,
    input  logic       tx_busy,
    input  logic [7:0] dec_d,
    input  logic       dec_d_rdy,
    input  logic       dec_err,
    output logic [7:0] rx_d,
    output logic       rx_d_rdy,
    output logic [7:0] rx_flag,
    output logic       rx_frame_end,
    output logic       rx_err,
    output logic       rx_busy,
    output logic [7:0] rx_err_cnt
);

    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

    logic [2:0]       state;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       pay_left;
    logic [15:0]      crc_rx;
    logic [15:0]      crc_calc;
    logic [7:0]       flag_len;
    logic             flag_known;
    logic             flag_take;
    logic             gap_exp;
    logic             in_frame;
    logic             abort;
    logic             crc_en;
    logic             crc_clr;

    always_comb begin
        flag_known = 1'b1;
        flag_len   = 8'd0;
        case (dec_d)
            FLAG_STATUS_REQUEST:       flag_len = 8'd0;
            FLAG_CONTROL_COMMAND_WORD: flag_len = 8'(CCW_LEN);
            FLAG_DATA_PACKET_REQUEST:  flag_len = 8'(DPR_LEN);
            default:                   flag_known = 1'b0;
        endcase
    end

    // A coincident dec_err kills the byte, so it never starts a frame either.
    assign flag_take = (state == ST_IDLE) & dec_d_rdy & ~dec_err & ~tx_busy;
    assign gap_exp   = (gap_cnt == GAP_W'(GAP_TIMEOUT));
    assign in_frame  = (state == ST_PAYLOAD) | (state == ST_CRC_HI) | (state == ST_CRC_LO);
    assign abort     = in_frame & (dec_err | gap_exp);
    assign crc_en    = flag_take | ((state == ST_PAYLOAD) & dec_d_rdy & ~abort);
    // Hold the CRC at init whenever no frame is being accumulated, so the next FLAG starts clean.
    assign crc_clr   = ((state == ST_IDLE) & ~flag_take) | (state == ST_CHECK) | (state == ST_DISCARD);
    assign rx_busy   = (state != ST_IDLE);

    crc16_citt_calc u_crc (
        .clk   (clk),
        .n_rst (n_rst & ~crc_clr),
        .en    (crc_en),
        .d     (dec_d),
        .crc   (crc_calc)
    );

    always_ff @(posedge clk) begin
        if (!n_rst || !(in_frame || state == ST_DISCARD) || dec_d_rdy || dec_err || abort)
            gap_cnt <= '0;
        else if (clk_en && !gap_exp)
            gap_cnt <= gap_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            pay_left     <= 8'd0;
            crc_rx       <= 16'd0;
            rx_d         <= 8'd0;
            rx_d_rdy     <= 1'b0;
            rx_flag      <= 8'd0;
            rx_frame_end <= 1'b0;
            rx_err       <= 1'b0;
        end else begin
            rx_d_rdy     <= 1'b0;
            rx_frame_end <= 1'b0;
            rx_err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flag_take) begin
                        rx_flag  <= dec_d;
                        pay_left <= flag_len;
                        if (!flag_known) begin
                            rx_err <= 1'b1;
                            state  <= ST_DISCARD;
                        end else if (flag_len == 8'd0) begin
                            state <= ST_CRC_HI;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD, ST_CRC_HI, ST_CRC_LO: begin
                    if (abort) begin
                        rx_err <= 1'b1;
                        state  <= ST_DISCARD;
                    end else if (dec_d_rdy) begin
                        if (state == ST_PAYLOAD) begin
                            rx_d     <= dec_d;
                            rx_d_rdy <= 1'b1;
                            pay_left <= pay_left - 8'd1;
                            if (pay_left == 8'd1) state <= ST_CRC_HI;
                        end else if (state == ST_CRC_HI) begin
                            crc_rx[15:8] <= dec_d;
                            state        <= ST_CRC_LO;
                        end else begin
                            crc_rx[7:0] <= dec_d;
                            state       <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (crc_calc == crc_rx) rx_frame_end <= 1'b1;
                    else                    rx_err       <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_DISCARD: begin
                    if (gap_exp) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HSI_RX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!n_rst)                            rx_err_cnt <= 8'd0;
        else if (rx_err && rx_err_cnt != 8'hFF) rx_err_cnt <= rx_err_cnt + 8'd1;
    end
`else
    assign rx_err_cnt = 8'd0;
`endif

endmodule
